// File: rtl/interleave_pkg.sv
// Shared types and helpers for the block interleaver.
// Width helpers keep declarations legal even for degenerate set/sample counts.
package interleave_pkg;
    localparam int BANKS   = 2;
    localparam int DEF_IIR = 3;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    typedef logic [clog2_min1(DEF_IIR)-1:0] set_idx_t;
endpackage

// File: rtl/interleave_bank_mem.sv
// Ping-pong sample storage: BANKS x IIR x N words, one synchronous write port
// and one combinational read port (the top-level output stage registers it).
module interleave_bank_mem
    import interleave_pkg::*;
#(
    parameter int BITS = 8,
    parameter int IIR  = 3,
    parameter int N    = 10,
    localparam int SW  = clog2_min1(IIR),
    localparam int IW  = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            we,
    input  logic            wr_bank,
    input  logic [SW-1:0]   wr_set,
    input  logic [IW-1:0]   wr_idx,
    input  logic [BITS-1:0] wr_data,
    input  logic            rd_bank,
    input  logic [SW-1:0]   rd_set,
    input  logic [IW-1:0]   rd_idx,
    output logic [BITS-1:0] rd_data
);
    logic [BITS-1:0] mem [BANKS][IIR][N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_set][wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_set][rd_idx];
endmodule

// File: rtl/interleave_block_input.sv
// Block interleaver: collects IIR set-major blocks of N samples per frame and
// emits them round-robin across sets, ping-ponging between two storage banks.
module interleave_block_input
    import interleave_pkg::*;
#(
    parameter int BITS = 8,
    parameter int IIR  = 3,
    parameter int N    = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BITS-1:0]        data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BITS-1:0]        data_out,
    output logic [$clog2(IIR)-1:0] out_set,
    output logic                   out_last
);
    localparam int SW = clog2_min1(IIR);
    localparam int IW = clog2_min1(N);
    localparam logic [SW-1:0] SET_LAST = SW'(IIR - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [SW-1:0] SET_ONE  = SW'(1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    logic [BANKS-1:0] full;
    logic             wr_bank, rd_bank;
    logic [SW-1:0]    wset, rset;
    logic [IW-1:0]    widx, ridx;
    logic [BITS-1:0]  rd_data;
    logic             accept, load, wr_end, rd_end;

    assign in_ready = !full[wr_bank] && !reset;
    assign accept   = in_valid && in_ready;
    assign load     = full[rd_bank] && (!out_valid || out_ready);
    assign wr_end   = (wset == SET_LAST) && (widx == IDX_LAST);
    assign rd_end   = (rset == SET_LAST) && (ridx == IDX_LAST);

    interleave_bank_mem #(
        .BITS (BITS),
        .IIR  (IIR),
        .N    (N)
    ) u_mem (
        .clk     (clk),
        .we      (accept),
        .wr_bank (wr_bank),
        .wr_set  (wset),
        .wr_idx  (widx),
        .wr_data (data_in),
        .rd_bank (rd_bank),
        .rd_set  (rset),
        .rd_idx  (ridx),
        .rd_data (rd_data)
    );

    // Write side walks samples within a set first, matching the input order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wset    <= '0;
            widx    <= '0;
            wr_bank <= 1'b0;
        end else if (accept) begin
            if (widx == IDX_LAST) begin
                widx <= '0;
                if (wset == SET_LAST) begin
                    wset    <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wset <= wset + SET_ONE;
                end
            end else begin
                widx <= widx + IDX_ONE;
            end
        end
    end

    // Fill and drain always target different banks, so both updates can land on one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= '0;
        end else begin
            if (accept && wr_end) begin
                full[wr_bank] <= 1'b1;
            end
            if (load && rd_end) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    // Read side walks sets first to produce the round-robin order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rset      <= '0;
            ridx      <= '0;
            rd_bank   <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            out_set   <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            data_out  <= rd_data;
            out_set   <= rset;
            out_last  <= rd_end;
            out_valid <= 1'b1;
            if (rset == SET_LAST) begin
                rset <= '0;
                if (ridx == IDX_LAST) begin
                    ridx    <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    ridx <= ridx + IDX_ONE;
                end
            end else begin
                rset <= rset + SET_ONE;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_interleave_block_input.sv
// Directed self-checking bench for interleave_block_input with IIR=3, N=4, BITS=8.
module tb_interleave_block_input;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] data_in = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] data_out;
    logic [1:0] out_set;
    logic       out_last;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    interleave_block_input #(.BITS(8), .IIR(3), .N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_set   (out_set),
        .out_last  (out_last)
    );

    // Edge log of handshakes and output-hold stability.
    int         cyc = 0;
    int         acc_cnt = 0;
    int         last_acc_cyc = 0;
    int         first_valid_cyc = -1;
    int         hold_cnt = 0;
    int         stab_err = 0;
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [1:0] hold_set = 2'b00;
    logic [7:0] oq_data[$];
    logic [1:0] oq_set[$];
    logic       oq_last[$];
    int         oq_cyc[$];

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (hold_pend) begin
                hold_cnt++;
                if (!out_valid || data_out !== hold_data || out_set !== hold_set) stab_err++;
            end
            if (out_valid && out_ready) begin
                oq_data.push_back(data_out);
                oq_set.push_back(out_set);
                oq_last.push_back(out_last);
                oq_cyc.push_back(cyc);
            end
            hold_pend = out_valid && !out_ready;
            hold_data = data_out;
            hold_set  = out_set;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_val(input int base, input int k);
        int f, r;
        f = k / 12;
        r = k % 12;
        return 8'(base + f * 12 + (r % 3) * 4 + r / 3);
    endfunction

    task automatic clear_log();
        oq_data.delete();
        oq_set.delete();
        oq_last.delete();
        oq_cyc.delete();
        first_valid_cyc = -1;
        hold_cnt = 0;
        stab_err = 0;
        acc_cnt = 0;
    endtask

    task automatic feed(input int base, input int count, input int gap);
        int i = 0;
        int guard = 0;
        int ph = 0;
        while (i < count && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (ph == 0) begin
                in_valid = 1'b1;
                data_in  = 8'(base + i);
                if (in_ready) i++;
            end else begin
                in_valid = 1'b0;
            end
            ph = (ph == gap) ? 0 : ph + 1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (i != count) begin
            bad++;
            $display("FAIL feed_timeout: accepted %0d required %0d", i, count);
        end
    endtask

    task automatic wait_out(input int n);
        int g = 0;
        while (oq_data.size() < n && g < 1000) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        if (data_out !== 8'h00) begin bad++; $display("FAIL rst_data_out: got %h required 00", data_out); end
        if (out_set !== 2'd0) begin bad++; $display("FAIL rst_out_set: got %0d required 0", out_set); end
        if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last: got %b required 0", out_last); end
        reset = 1'b0;
        @(negedge clk);
        total += 2;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b required 1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_out_valid: got %b required 0", out_valid); end
    endtask

    task automatic test_single();
        logic [7:0] exp_single [12];
        exp_single = '{8'h00, 8'h04, 8'h08, 8'h01, 8'h05, 8'h09,
                       8'h02, 8'h06, 8'h0A, 8'h03, 8'h07, 8'h0B};
        clear_log();
        out_ready = 1'b1;
        feed(0, 12, 0);
        wait_out(12);
        repeat (2) @(negedge clk);
        total += 3;
        if (oq_data.size() != 12) begin bad++; $display("FAIL single_count: got %0d required 12", oq_data.size()); end
        if (first_valid_cyc - last_acc_cyc != 2) begin
            bad++;
            $display("FAIL single_latency: got %0d required 2", first_valid_cyc - last_acc_cyc);
        end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_idle: out_valid got %b required 0", out_valid); end
        for (int i = 0; i < 12 && i < oq_data.size(); i++) begin
            total += 3;
            if (oq_data[i] !== exp_single[i]) begin bad++; $display("FAIL single_data[%0d]: got %h required %h", i, oq_data[i], exp_single[i]); end
            if (oq_set[i] !== 2'(i % 3)) begin bad++; $display("FAIL single_set[%0d]: got %0d required %0d", i, oq_set[i], i % 3); end
            if (oq_last[i] !== (i == 11)) begin bad++; $display("FAIL single_last[%0d]: got %b required %b", i, oq_last[i], i == 11); end
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        out_ready = 1'b1;
        feed(0, 36, 0);
        wait_out(36);
        total++;
        if (oq_data.size() != 36) begin bad++; $display("FAIL b2b_count: got %0d required 36", oq_data.size()); end
        for (int i = 0; i < 36 && i < oq_data.size(); i++) begin
            total += 4;
            if (oq_data[i] !== exp_val(0, i)) begin bad++; $display("FAIL b2b_data[%0d]: got %h required %h", i, oq_data[i], exp_val(0, i)); end
            if (oq_set[i] !== 2'(i % 3)) begin bad++; $display("FAIL b2b_set[%0d]: got %0d required %0d", i, oq_set[i], i % 3); end
            if (oq_last[i] !== (i % 12 == 11)) begin bad++; $display("FAIL b2b_last[%0d]: got %b required %b", i, oq_last[i], i % 12 == 11); end
            if (oq_cyc[i] - oq_cyc[0] != i) begin bad++; $display("FAIL b2b_gap[%0d]: offset %0d required %0d", i, oq_cyc[i] - oq_cyc[0], i); end
        end
    endtask

    task automatic test_both_full();
        clear_log();
        out_ready = 1'b0;
        feed(8'h80, 24, 0);
        repeat (3) @(negedge clk);
        total += 4;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b required 0", in_ready); end
        if (out_valid !== 1'b1) begin bad++; $display("FAIL full_out_valid: got %b required 1", out_valid); end
        if (data_out !== 8'h80) begin bad++; $display("FAIL full_data_hold: got %h required 80", data_out); end
        if (out_set !== 2'd0) begin bad++; $display("FAIL full_set_hold: got %0d required 0", out_set); end
        out_ready = 1'b1;
        wait_out(24);
        @(negedge clk);
        total += 2;
        if (oq_data.size() != 24) begin bad++; $display("FAIL full_count: got %0d required 24", oq_data.size()); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL full_drained_in_ready: got %b required 1", in_ready); end
        for (int i = 0; i < 24 && i < oq_data.size(); i++) begin
            total++;
            if (oq_data[i] !== exp_val(8'h80, i)) begin bad++; $display("FAIL full_data[%0d]: got %h required %h", i, oq_data[i], exp_val(8'h80, i)); end
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        fork
            feed(0, 12, 0);
            begin
                int g = 0;
                while (oq_data.size() < 12 && g < 1000) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                    g++;
                end
            end
        join
        out_ready = 1'b1;
        total += 3;
        if (oq_data.size() != 12) begin bad++; $display("FAIL bp_count: got %0d required 12", oq_data.size()); end
        if (stab_err != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable holds required 0", stab_err); end
        if (hold_cnt == 0) begin bad++; $display("FAIL bp_exercised: got %0d stalled cycles required >0", hold_cnt); end
        for (int i = 0; i < 12 && i < oq_data.size(); i++) begin
            total += 2;
            if (oq_data[i] !== exp_val(0, i)) begin bad++; $display("FAIL bp_data[%0d]: got %h required %h", i, oq_data[i], exp_val(0, i)); end
            if (oq_set[i] !== 2'(i % 3)) begin bad++; $display("FAIL bp_set[%0d]: got %0d required %0d", i, oq_set[i], i % 3); end
        end
    endtask

    task automatic test_gaps();
        clear_log();
        out_ready = 1'b1;
        feed(0, 12, 2);
        wait_out(12);
        total += 3;
        if (acc_cnt != 12) begin bad++; $display("FAIL gap_accepts: got %0d required 12", acc_cnt); end
        if (first_valid_cyc - last_acc_cyc != 2) begin
            bad++;
            $display("FAIL gap_latency: got %0d required 2", first_valid_cyc - last_acc_cyc);
        end
        if (oq_data.size() != 12) begin bad++; $display("FAIL gap_count: got %0d required 12", oq_data.size()); end
        for (int i = 0; i < 12 && i < oq_data.size(); i++) begin
            total++;
            if (oq_data[i] !== exp_val(0, i)) begin bad++; $display("FAIL gap_data[%0d]: got %h required %h", i, oq_data[i], exp_val(0, i)); end
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        out_ready = 1'b1;
        feed(8'h30, 7, 0);
        total++;
        if (oq_data.size() != 0) begin bad++; $display("FAIL mid_partial_out: got %0d required 0", oq_data.size()); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_log();
        feed(8'h40, 12, 0);
        wait_out(12);
        repeat (3) @(negedge clk);
        total += 2;
        if (oq_data.size() != 12) begin bad++; $display("FAIL mid_count: got %0d required 12", oq_data.size()); end
        if (first_valid_cyc - last_acc_cyc != 2) begin
            bad++;
            $display("FAIL mid_latency: got %0d required 2", first_valid_cyc - last_acc_cyc);
        end
        for (int i = 0; i < 12 && i < oq_data.size(); i++) begin
            total++;
            if (oq_data[i] !== exp_val(8'h40, i)) begin bad++; $display("FAIL mid_data[%0d]: got %h required %h", i, oq_data[i], exp_val(8'h40, i)); end
        end
    endtask

    task automatic test_reset_drain();
        int g = 0;
        clear_log();
        out_ready = 1'b1;
        feed(8'h50, 12, 0);
        while (oq_data.size() < 5 && g < 500) begin
            @(negedge clk);
            g++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_rst_out_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_rst_in_ready: got %b required 1", in_ready); end
        repeat (20) @(negedge clk);
        total++;
        if (oq_data.size() != 5) begin bad++; $display("FAIL drain_stale: got %0d outputs required 5", oq_data.size()); end
        for (int i = 0; i < 5 && i < oq_data.size(); i++) begin
            total++;
            if (oq_data[i] !== exp_val(8'h50, i)) begin bad++; $display("FAIL drain_pre_data[%0d]: got %h required %h", i, oq_data[i], exp_val(8'h50, i)); end
        end
        clear_log();
        feed(8'h60, 12, 0);
        wait_out(12);
        repeat (3) @(negedge clk);
        total++;
        if (oq_data.size() != 12) begin bad++; $display("FAIL drain_new_count: got %0d required 12", oq_data.size()); end
        for (int i = 0; i < 12 && i < oq_data.size(); i++) begin
            total++;
            if (oq_data[i] !== exp_val(8'h60, i)) begin bad++; $display("FAIL drain_new_data[%0d]: got %h required %h", i, oq_data[i], exp_val(8'h60, i)); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_both_full();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_reset_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
